// File: rtl/countdown_4bit_reload.sv
// Loadable down-counter with one-shot / auto-reload modes and a registered
// terminal-count pulse, controlled by a three-state IDLE/RUN/EXPIRED machine.
module countdown_4bit_reload #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             busy,
   output logic             expired
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_EXPIRED = 2'd2
   } state_e;

   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] reload_q;
   logic [WIDTH-1:0] reload_d;
   logic             tc_q;
   logic             tc_d;

   // Next-state logic: clr beats load, load beats counting, otherwise hold.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      tc_d     = 1'b0;

      if (clr) begin
         count_d = CNT_ZERO;
         state_d = ST_IDLE;
      end else if (load) begin
         count_d  = load_val;
         reload_d = load_val;
         if (load_val != CNT_ZERO) begin
            state_d = ST_RUN;
         end else begin
            state_d = ST_IDLE;
         end
      end else begin
         case (state_q)
            ST_RUN: begin
               if (en) begin
                  if (count_q > CNT_ONE) begin
                     count_d = count_q - CNT_ONE;
                  end else if (count_q == CNT_ONE) begin
                     tc_d = 1'b1;
                     if (auto_reload) begin
                        count_d = reload_q;
                     end else begin
                        count_d = CNT_ZERO;
                        state_d = ST_EXPIRED;
                     end
                  end else begin
                     // A zero count in RUN is unreachable; park safely without a pulse.
                     count_d = CNT_ZERO;
                     state_d = ST_IDLE;
                  end
               end else begin
                  count_d = count_q;
                  state_d = ST_RUN;
               end
            end
            ST_IDLE: begin
               count_d = count_q;
               state_d = ST_IDLE;
            end
            ST_EXPIRED: begin
               count_d = count_q;
               state_d = ST_EXPIRED;
            end
            default: begin
               count_d = CNT_ZERO;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, count, reload value and terminal-count pulse registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         count_q  <= CNT_ZERO;
         reload_q <= CNT_ZERO;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
      end
   end

   assign q       = count_q;
   assign tc      = tc_q;
   assign busy    = (state_q == ST_RUN);
   assign expired = (state_q == ST_EXPIRED);

endmodule

// File: doc/countdown_4bit_reload.md
COUNTDOWN_4BIT_RELOAD -- requirements
Module: countdown_4bit_reload

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the counter and load-value width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port clr, input, 1, synchronous clear request.
REQ-005 The block SHALL have port load, input, 1, synchronous load request.
REQ-006 The block SHALL have port load_val, input, WIDTH, the start/reload count, sampled when load=1.
REQ-007 The block SHALL have port en, input, 1, the count enable.
REQ-008 The block SHALL have port auto_reload, input, 1, the reload-mode select, sampled each cycle.
REQ-009 The block SHALL have port q, output, WIDTH, the current count, registered.
REQ-010 The block SHALL have port tc, output, 1, the terminal-count pulse, registered.
REQ-011 The block SHALL have port busy, output, 1, high exactly when state=RUN.
REQ-012 The block SHALL have port expired, output, 1, high exactly when state=EXPIRED.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, EXPIRED.
REQ-014 The block SHALL hold an internal WIDTH-bit register reload_reg.
REQ-015 Priority per cycle SHALL be clr > load > count > hold.
REQ-016 When clr=1 the block SHALL set q=0 and state=IDLE next cycle, leave reload_reg unchanged and drive tc=0; this applies in any state.
REQ-017 When clr=0 and load=1 with load_val!=0, the block SHALL set q=load_val, reload_reg=load_val and state=RUN next cycle, with no decrement that cycle.
REQ-018 When clr=0 and load=1 with load_val=0, the block SHALL set q=0, reload_reg=0 and state=IDLE, with tc=0.
REQ-019 In RUN with en=1, no clr, no load and q>1, the block SHALL set q=q-1.
REQ-020 In RUN with en=1, no clr, no load, q=1 and auto_reload=0, the block SHALL set q=0, state=EXPIRED and tc=1 for exactly one cycle.
REQ-021 In RUN with en=1, no clr, no load, q=1 and auto_reload=1, the block SHALL set q=reload_reg, stay in RUN and drive tc=1 for exactly one cycle. The tc period SHALL be reload_reg enabled cycles.
REQ-022 In RUN with en=0, the block SHALL hold q and state and drive tc=0.
REQ-023 In IDLE and EXPIRED, the block SHALL hold q and SHALL ignore en and auto_reload.
REQ-024 The block SHALL leave EXPIRED only on clr or load.
REQ-025 q SHALL never decrement from 0; no underflow wrap is permitted.
REQ-026 tc SHALL be 0 in every cycle not covered by REQ-020/REQ-021, and SHALL never be high two consecutive cycles unless reload_reg=1 with auto_reload=1 and en held high.
REQ-027 A load arriving in the same cycle as the q=1 decrement SHALL win: q=load_val, with no tc.
REQ-028 A change to auto_reload mid-count SHALL take effect at the next q=1 decrement.

Reset
REQ-029 While rst=0, the block SHALL immediately, asynchronously, force q=0, reload_reg=0, state=IDLE, tc=0, busy=0 and expired=0.
REQ-030 Reset assertion mid-count SHALL abort the count and produce no tc pulse.
REQ-031 After rst is deasserted, the block SHALL first respond to inputs at the next posedge clk, with no spurious tc.

Verification
REQ-032 One-shot: load_val=3 and load, then en=1 held with auto_reload=0 -> q sequence 3,2,1,0; tc=1 only in the cycle q first reads 0; expired=1 and q=0 thereafter.
REQ-033 Auto-reload: load_val=4, auto_reload=1, en=1 held -> q 4,3,2,1,4,3,...; tc high once every 4 cycles, aligned with q returning to 4; busy stays 1.
REQ-034 Enable gaps: load 5, en toggling 1,0,1,0 -> q steps only on en=1 cycles (5,4,4,3,3); tc=0.
REQ-035 Collisions: clr and load in the same cycle -> q=0 and IDLE. Load 7 in the same cycle as q=1 with en=1 -> q=7 with tc=0.
REQ-036 Zero load and expiry: load_val=0 -> IDLE, q=0; en pulses -> no change; in EXPIRED, en=1 -> q stays 0 with tc=0.
REQ-037 Asynchronous reset: assert rst=0 mid-cycle at q=2 -> q=0 and busy=0 before the next edge; release -> IDLE with no tc.
